// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: accepts exception/MRET/interrupt requests in IDLE,
// then walks FLUSH -> SAVE -> REDIRECT to update trap CSRs and steer the front end.
module trap_ctrl #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned CAUSE_W  = 4,
  parameter int unsigned IRQ_CODE = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exc_valid,
  input  logic [CAUSE_W-1:0] exc_cause,
  input  logic [XLEN-1:0]    exc_pc,
  input  logic [XLEN-1:0]    exc_tval,
  input  logic               mret_valid,
  input  logic               irq_ext,
  input  logic               mstatus_mie,
  input  logic               mie_meie,
  input  logic [XLEN-1:0]    mem_pc,
  input  logic               mem_pc_valid,
  input  logic [XLEN-1:0]    mtvec,
  input  logic [XLEN-1:0]    mepc_in,
  output logic               busy,
  output logic               flush,
  output logic               stall,
  output logic               csr_we,
  output logic [XLEN-1:0]    mepc_out,
  output logic [XLEN-1:0]    mcause_out,
  output logic [XLEN-1:0]    mtval_out,
  output logic               trap_enter,
  output logic               trap_exit,
  output logic               redirect_valid,
  output logic [XLEN-1:0]    redirect_pc
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] IRQ_CAUSE  = {1'b1, (XLEN-1)'(IRQ_CODE)};
  localparam logic [XLEN-1:0] IRQ_OFFSET = XLEN'(4 * IRQ_CODE);

  typedef enum logic [1:0] {IDLE, FLUSH, SAVE, REDIRECT} state_t;
  typedef enum logic [1:0] {K_NONE, K_EXC, K_MRET, K_IRQ} kind_t;

  state_t          state;
  kind_t           kind;
  logic [XLEN-1:0] epc;
  logic [XLEN-1:0] cause;
  logic [XLEN-1:0] tval;
  logic            irq_take;

  assign irq_take = irq_ext & mstatus_mie & mie_meie & mem_pc_valid;

  // State register and trap-context latches; requests are only looked at in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      kind  <= K_NONE;
      epc   <= '0;
      cause <= '0;
      tval  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (exc_valid) begin
            kind  <= K_EXC;
            epc   <= exc_pc;
            cause <= XLEN'(exc_cause);
            tval  <= exc_tval;
            state <= FLUSH;
          end else if (mret_valid) begin
            kind  <= K_MRET;
            state <= FLUSH;
          end else if (irq_take) begin
            kind  <= K_IRQ;
            epc   <= mem_pc;
            cause <= IRQ_CAUSE;
            tval  <= '0;
            state <= FLUSH;
          end
        end
        FLUSH:    state <= (kind == K_MRET) ? REDIRECT : SAVE;
        SAVE:     state <= REDIRECT;
        REDIRECT: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // Outputs decode the state register only; CSR inputs are read live in REDIRECT.
  always_comb begin
    busy           = 1'b0;
    flush          = 1'b0;
    stall          = 1'b0;
    csr_we         = 1'b0;
    mepc_out       = '0;
    mcause_out     = '0;
    mtval_out      = '0;
    trap_enter     = 1'b0;
    trap_exit      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state)
      FLUSH: begin
        busy  = 1'b1;
        flush = 1'b1;
        stall = 1'b1;
      end
      SAVE: begin
        busy       = 1'b1;
        stall      = 1'b1;
        csr_we     = 1'b1;
        trap_enter = 1'b1;
        mepc_out   = epc & ALIGN_MASK;
        mcause_out = cause;
        mtval_out  = tval;
      end
      REDIRECT: begin
        busy           = 1'b1;
        flush          = 1'b1;
        redirect_valid = 1'b1;
        if (kind == K_MRET) begin
          trap_exit   = 1'b1;
          redirect_pc = mepc_in & ALIGN_MASK;
        end else if (kind == K_IRQ && mtvec[1:0] == 2'b01) begin
          redirect_pc = (mtvec & ALIGN_MASK) + IRQ_OFFSET;
        end else begin
          redirect_pc = mtvec & ALIGN_MASK;
        end
      end
      default: ;
    endcase
  end

endmodule
